bp_resolve_queue: RTL and testbench
===================================

// Module: bp_resolve_queue
// PURPOSE
//  In-order buffer between the fetch-side predictor lookup and the 2-bit counter FSM.
//  - Holds each predicted branch's {PHT index, counter state} until the branch resolves.
//  - On resolution, emits an update (torn + old state) that drives the FSM's torn/in_data inputs.
//  - Flags mispredicts.
//  - Forwards pending counter changes to younger queued entries with the same index,
//    hiding the FSM's write-back latency.
// PARAMETERS
//  DEPTH  8  queue entries; power of 2, >=2
//  IDX_W  6  PHT index width
//  ST_W   2  counter state width; encoding 00 WELL_NTAKEN, 01 NTAKEN, 10 TAKEN, 11 WELL_TAKEN
// PORTS
//  clk         in   1          rising-edge clock
//  reset       in   1          synchronous, active-low (0 = reset)
//  pred_valid  in   1          fetch presents a predicted branch
//  pred_idx    in   IDX_W      PHT index of that branch
//  pred_state  in   ST_W       counter state read at prediction time
//  pred_ready  out  1          entry accepted this cycle when pred_valid & pred_ready
//  res_valid   in   1          oldest outstanding branch resolved
//  res_taken   in   1          actual direction (1 = taken)
//  res_ready   out  1          resolution accepted this cycle when res_valid & res_ready
//  flush       in   1          discard all queued entries
//  upd_valid   out  1          update beat (one cycle)
//  upd_idx     out  IDX_W      index to write back
//  upd_torn    out  1          actual direction -> FSM torn
//  upd_state   out  ST_W       state used for prediction, after forwarding -> FSM in_data
//  mispredict  out  1          upd_state[1] != upd_torn; valid with upd_valid
//  count       out  $clog2(DEPTH)+1  occupancy
//  err_underrun out 1          sticky: res_valid seen while queue empty
// BEHAVIOUR
//  - Reset (reset==0 at posedge): pointers, count = 0.
//    - upd_valid, mispredict, err_underrun = 0; upd_idx, upd_torn, upd_state = 0.
//    - pred_ready = 1, res_ready = 0.
//  - Readiness: pred_ready = (count != DEPTH); res_ready = (count != 0).
//    - Both are combinational from registered count only.
//    - A full queue does not accept an enqueue, even in the same cycle as a pop.
//  - Enqueue: on pred_valid & pred_ready, write {pred_idx, pred_state} at the tail; tail advances.
//  - Pop: on res_valid & res_ready, read the head; head advances. Next cycle (1-cycle latency):
//    - upd_valid = 1
//    - upd_idx = head.idx
//    - upd_torn = res_taken
//    - upd_state = head.state
//    - mispredict = head.state[1] ^ res_taken
//  - Otherwise upd_valid = 0 and mispredict = 0; data outputs hold their last values.
//  - Counter next-state function nxt(s, t):
//    - t = 1: saturating +1 (11 stays 11).
//    - t = 0: saturating -1 (00 stays 00).
//  - Forwarding on each pop of index X with outcome t:
//    - Every other valid entry with idx == X gets state <= nxt(head.state, t).
//    - A same-cycle enqueue with pred_idx == X is written with nxt(head.state, t) instead of pred_state.
//  - Simultaneous enqueue and pop: both occur; count unchanged. Pointers wrap modulo DEPTH.
//  - Underrun: res_valid while count == 0.
//    - Ignored: no pop, no update.
//    - err_underrun <= 1 and holds until reset.
//  - Flush has priority over the same-cycle enqueue and pop:
//    - Pointers and count <= 0.
//    - upd_valid and mispredict <= 0 next cycle.
//    - err_underrun is unaffected.
//  - Reset mid-operation discards all entries; no update beat is emitted for them.
// TESTING
//  1. Reset, enqueue idx=5 state=01, resolve taken
//     -> next cycle upd_valid=1, idx=5, torn=1, state=01, mispredict=1; count 1->0.
//  2. Fill with 8 entries -> pred_ready=0; a 9th pred_valid is dropped.
//     - Pop + enqueue in one cycle at count=7 keeps count=7.
//  3. Queue idx=3 state=10 twice; resolve first taken
//     -> second entry becomes 11; resolve it not-taken -> upd_state=11, mispredict=1.
//  4. Pop idx=9 (state 00, taken) in the same cycle as enqueue idx=9 state=00
//     -> queued state=01.
//  5. Count=4, flush asserted with res_valid=1
//     -> next cycle count=0, upd_valid=0, pred_ready=1.
//  6. res_valid=1 on empty queue -> no upd_valid, err_underrun=1 until reset==0.

Source files
------------

// File: rtl/bp_resolve_queue.sv
// bp_resolve_queue
//   In-order buffer between the fetch-side predictor lookup and the 2-bit
//   counter FSM. Each predicted branch leaves its {PHT index, counter state}
//   here until it resolves. On resolution a one-cycle update beat carries the
//   index, the actual direction and the old state to the FSM write-back path.
//   Pending counter changes are forwarded to younger queued entries that share
//   the index, which hides the FSM write-back latency.
//
// Ports
//   clk, reset               rising-edge clock, synchronous active-low reset
//   pred_valid/idx/state     enqueue request from fetch; pred_ready = not full
//   res_valid/res_taken      resolution of the oldest entry; res_ready = not empty
//   flush                    discard every queued entry
//   upd_valid/idx/torn/state registered update beat (1-cycle latency after pop)
//   mispredict               upd_state MSB differs from upd_torn, with upd_valid
//   count                    occupancy
//   err_underrun             sticky: res_valid seen on an empty queue
module bp_resolve_queue #(
   parameter int DEPTH = 8,
   parameter int IDX_W = 6,
   parameter int ST_W  = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       pred_valid,
   input  logic [IDX_W-1:0]           pred_idx,
   input  logic [ST_W-1:0]            pred_state,
   output logic                       pred_ready,
   input  logic                       res_valid,
   input  logic                       res_taken,
   output logic                       res_ready,
   input  logic                       flush,
   output logic                       upd_valid,
   output logic [IDX_W-1:0]           upd_idx,
   output logic                       upd_torn,
   output logic [ST_W-1:0]            upd_state,
   output logic                       mispredict,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       err_underrun
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // Saturating counter step: +1 on taken, -1 on not-taken.
   function automatic logic [ST_W-1:0] nxt(input logic [ST_W-1:0] s, input logic t);
      logic [ST_W-1:0] r;
      r = s;
      if (t) begin
         if (s != '1) r = s + ST_W'(1);
      end else begin
         if (s != '0) r = s - ST_W'(1);
      end
      return r;
   endfunction

   logic [IDX_W-1:0] idx_q [DEPTH];
   logic [IDX_W-1:0] idx_d [DEPTH];
   logic [ST_W-1:0]  st_q  [DEPTH];
   logic [ST_W-1:0]  st_d  [DEPTH];
   logic [DEPTH-1:0] vld_q, vld_d;
   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             upd_valid_q, upd_valid_d;
   logic [IDX_W-1:0] upd_idx_q, upd_idx_d;
   logic             upd_torn_q, upd_torn_d;
   logic [ST_W-1:0]  upd_state_q, upd_state_d;
   logic             mis_q, mis_d;
   logic             err_q, err_d;

   logic             push, pop;
   logic [IDX_W-1:0] head_idx;
   logic [ST_W-1:0]  head_st, fwd_st;

   assign pred_ready   = (count_q != CNT_W'(DEPTH));
   assign res_ready    = (count_q != '0);
   assign count        = count_q;
   assign upd_valid    = upd_valid_q;
   assign upd_idx      = upd_idx_q;
   assign upd_torn     = upd_torn_q;
   assign upd_state    = upd_state_q;
   assign mispredict   = mis_q;
   assign err_underrun = err_q;

   always_comb begin
      idx_d       = idx_q;
      st_d        = st_q;
      vld_d       = vld_q;
      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;
      upd_valid_d = 1'b0;
      upd_idx_d   = upd_idx_q;
      upd_torn_d  = upd_torn_q;
      upd_state_d = upd_state_q;
      mis_d       = 1'b0;
      err_d       = err_q | (res_valid & (count_q == '0));

      push     = pred_valid & pred_ready & ~flush;
      pop      = res_valid & res_ready & ~flush;
      head_idx = idx_q[head_q];
      head_st  = st_q[head_q];
      fwd_st   = nxt(head_st, res_taken);

      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
         vld_d   = '0;
      end else begin
         if (pop) begin
            // Younger entries aliasing the resolving index see the post-update counter.
            for (int i = 0; i < DEPTH; i++) begin
               if (vld_q[i] && (PTR_W'(i) != head_q) && (idx_q[i] == head_idx))
                  st_d[i] = fwd_st;
            end
            vld_d[head_q] = 1'b0;
            head_d        = head_q + PTR_W'(1);
            upd_valid_d   = 1'b1;
            upd_idx_d     = head_idx;
            upd_torn_d    = res_taken;
            upd_state_d   = head_st;
            mis_d         = head_st[ST_W-1] ^ res_taken;
         end
         if (push) begin
            idx_d[tail_q] = pred_idx;
            st_d[tail_q]  = (pop && (pred_idx == head_idx)) ? fwd_st : pred_state;
            vld_d[tail_q] = 1'b1;
            tail_d        = tail_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Storage stage: entry payloads carry no reset; validity is tracked by vld_q.
   always_ff @(posedge clk) begin
      idx_q <= idx_d;
      st_q  <= st_d;
   end

   // Control and update-beat stage.
   always_ff @(posedge clk) begin
      if (!reset) begin
         vld_q       <= '0;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         upd_valid_q <= 1'b0;
         upd_idx_q   <= '0;
         upd_torn_q  <= 1'b0;
         upd_state_q <= '0;
         mis_q       <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         vld_q       <= vld_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         upd_valid_q <= upd_valid_d;
         upd_idx_q   <= upd_idx_d;
         upd_torn_q  <= upd_torn_d;
         upd_state_q <= upd_state_d;
         mis_q       <= mis_d;
         err_q       <= err_d;
      end
   end

endmodule

// File: tb/tb_bp_resolve_queue.sv
// tb_bp_resolve_queue
//   Directed stimulus with hand-computed expected update beats. Expected beats
//   are queued when a resolution is issued; a monitor pops and compares every
//   beat the DUT presents. Occupancy, readiness and error flags are checked
//   inline by the stimulus process.
module tb_bp_resolve_queue;

   logic       clk = 1'b0;
   logic       reset;
   logic       pred_valid;
   logic [5:0] pred_idx;
   logic [1:0] pred_state;
   logic       pred_ready;
   logic       res_valid;
   logic       res_taken;
   logic       res_ready;
   logic       flush;
   logic       upd_valid;
   logic [5:0] upd_idx;
   logic       upd_torn;
   logic [1:0] upd_state;
   logic       mispredict;
   logic [3:0] count;
   logic       err_underrun;

   bp_resolve_queue #(.DEPTH(8), .IDX_W(6), .ST_W(2)) dut (
      .clk(clk), .reset(reset),
      .pred_valid(pred_valid), .pred_idx(pred_idx), .pred_state(pred_state), .pred_ready(pred_ready),
      .res_valid(res_valid), .res_taken(res_taken), .res_ready(res_ready),
      .flush(flush),
      .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_torn(upd_torn), .upd_state(upd_state),
      .mispredict(mispredict), .count(count), .err_underrun(err_underrun)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [5:0] idx;
      logic       torn;
      logic [1:0] st;
      logic       mis;
   } upd_t;

   upd_t sb[$];
   upd_t mon_e;
   int   n_tests = 0;
   int   n_fail  = 0;

   // Monitor: every update beat must match the oldest expected beat.
   always @(negedge clk) begin
      if (reset === 1'b1 && upd_valid === 1'b1) begin
         n_tests++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL upd_unexpected: got idx=%0d torn=%0d state=%0d mis=%0d, required no beat",
                     upd_idx, upd_torn, upd_state, mispredict);
         end else begin
            mon_e = sb.pop_front();
            if ({upd_idx, upd_torn, upd_state, mispredict} !== mon_e) begin
               n_fail++;
               $display("FAIL upd_beat: got idx=%0d torn=%0d state=%0d mis=%0d, required idx=%0d torn=%0d state=%0d mis=%0d",
                        upd_idx, upd_torn, upd_state, mispredict, mon_e.idx, mon_e.torn, mon_e.st, mon_e.mis);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", nm, act, exp);
      end
   endtask

   task automatic expect_upd(input logic [5:0] i, input logic t, input logic [1:0] s, input logic m);
      upd_t e;
      e.idx  = i;
      e.torn = t;
      e.st   = s;
      e.mis  = m;
      sb.push_back(e);
   endtask

   task automatic step(input logic pv, input logic [5:0] pi, input logic [1:0] ps,
                       input logic rv, input logic rt, input logic fl);
      pred_valid = pv;
      pred_idx   = pi;
      pred_state = ps;
      res_valid  = rv;
      res_taken  = rt;
      flush      = fl;
      @(posedge clk);
      #1;
      pred_valid = 1'b0;
      res_valid  = 1'b0;
      flush      = 1'b0;
   endtask

   task automatic push(input logic [5:0] i, input logic [1:0] s);
      step(1'b1, i, s, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic pop(input logic t);
      step(1'b0, 6'd0, 2'd0, 1'b1, t, 1'b0);
   endtask

   task automatic idle();
      step(1'b0, 6'd0, 2'd0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      reset = 1'b0;
      pred_valid = 1'b0; pred_idx = '0; pred_state = '0;
      res_valid = 1'b0; res_taken = 1'b0; flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_count", count, 0);
      chk("rst_pred_ready", pred_ready, 1);
      chk("rst_res_ready", res_ready, 0);
      chk("rst_upd_valid", upd_valid, 0);
      chk("rst_upd_data", {upd_idx, upd_torn, upd_state}, 0);
      chk("rst_mispredict", mispredict, 0);
      chk("rst_err", err_underrun, 0);
      reset = 1'b1;
      idle();

      // 1: single entry, taken resolve of a not-taken prediction
      push(6'd5, 2'b01);
      chk("t1_count1", count, 1);
      chk("t1_res_ready", res_ready, 1);
      expect_upd(6'd5, 1'b1, 2'b01, 1'b1);
      pop(1'b1);
      chk("t1_count0", count, 0);

      // 2: fill, drop 9th, full + pop drops push, pop+push at 7 holds count
      for (int i = 0; i < 8; i++) push(6'(16 + i), 2'b10);
      chk("t2_full_count", count, 8);
      chk("t2_full_pred_ready", pred_ready, 0);
      push(6'd40, 2'b11);
      chk("t2_drop_count", count, 8);
      expect_upd(6'd16, 1'b1, 2'b10, 1'b0);
      step(1'b1, 6'd40, 2'b11, 1'b1, 1'b1, 1'b0);
      chk("t2_full_pop_count", count, 7);
      expect_upd(6'd17, 1'b1, 2'b10, 1'b0);
      step(1'b1, 6'd41, 2'b01, 1'b1, 1'b1, 1'b0);
      chk("t2_popush_count", count, 7);
      for (int i = 0; i < 6; i++) begin
         expect_upd(6'(18 + i), 1'b0, 2'b10, 1'b1);
         pop(1'b0);
      end
      expect_upd(6'd41, 1'b0, 2'b01, 1'b0);
      pop(1'b0);
      chk("t2_drained", count, 0);

      // 3: forwarding to a younger same-index entry
      push(6'd3, 2'b10);
      push(6'd3, 2'b10);
      expect_upd(6'd3, 1'b1, 2'b10, 1'b0);
      pop(1'b1);
      expect_upd(6'd3, 1'b0, 2'b11, 1'b1);
      pop(1'b0);

      // 4: forwarding into a same-cycle enqueue
      push(6'd9, 2'b00);
      expect_upd(6'd9, 1'b1, 2'b00, 1'b1);
      step(1'b1, 6'd9, 2'b00, 1'b1, 1'b1, 1'b0);
      expect_upd(6'd9, 1'b0, 2'b01, 1'b0);
      pop(1'b0);

      // saturation at both ends
      push(6'd7, 2'b11);
      push(6'd7, 2'b11);
      expect_upd(6'd7, 1'b1, 2'b11, 1'b0);
      pop(1'b1);
      expect_upd(6'd7, 1'b1, 2'b11, 1'b0);
      pop(1'b1);
      push(6'd2, 2'b00);
      push(6'd2, 2'b00);
      expect_upd(6'd2, 1'b0, 2'b00, 1'b0);
      pop(1'b0);
      expect_upd(6'd2, 1'b0, 2'b00, 1'b0);
      pop(1'b0);

      // 5: flush beats same-cycle pop and enqueue
      for (int i = 0; i < 4; i++) push(6'(30 + i), 2'b01);
      chk("t5_count4", count, 4);
      step(1'b1, 6'd50, 2'b01, 1'b1, 1'b1, 1'b1);
      chk("t5_count0", count, 0);
      chk("t5_upd_valid", upd_valid, 0);
      chk("t5_pred_ready", pred_ready, 1);
      chk("t5_res_ready", res_ready, 0);
      push(6'd51, 2'b01);
      expect_upd(6'd51, 1'b1, 2'b01, 1'b1);
      pop(1'b1);

      // 6: underrun is ignored and sticky
      chk("t6_err_before", err_underrun, 0);
      pop(1'b1);
      chk("t6_err_set", err_underrun, 1);
      chk("t6_no_upd", upd_valid, 0);
      chk("t6_count", count, 0);
      push(6'd12, 2'b10);
      push(6'd13, 2'b10);
      chk("t6_err_hold", err_underrun, 1);

      // reset mid-operation discards entries without update beats
      reset = 1'b0;
      idle();
      chk("rst2_count", count, 0);
      chk("rst2_err", err_underrun, 0);
      chk("rst2_upd_valid", upd_valid, 0);
      reset = 1'b1;
      repeat (3) idle();
      chk("sb_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
